// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, instruction field positions and defaults for
//               the decode/operand-issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_AW_DEFAULT = 4;
    localparam int IMM_W_DEFAULT  = 16;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    // Instruction word field positions (LSB of each field)
    localparam int OP_LSB      = 29;
    localparam int IMM_SEL_BIT = 28;
    localparam int RD_LSB      = 24;
    localparam int RS1_LSB     = 20;
    localparam int RS2_LSB     = 16;
    localparam int IMM_LSB     = 0;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_MOV, OP_ADD, OP_XOR, OP_OR, OP_AND: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cpu_regfile
// Description : Register file with two operand read ports, one debug read
//               port and one synchronous write port. r0 reads as zero and
//               ignores writes; async reset clears every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [31:0]       rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [31:0]       rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    localparam int NREGS = 2 ** REG_AW;

    logic [31:0] regs [NREGS];

    // Storage: cleared on reset, written at the clock edge except for r0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    assign dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/cpu_issue.sv
`default_nettype none
// ============================================================================
// Module      : cpu_issue
// Description : Decode/operand-issue stage feeding a combinational ALU.
//               Reads operands, drives registered alu_op/alu_a/alu_b for one
//               EX cycle and writes alu_res back at the end of that cycle.
//               RAW hazards against the EX instruction stall one cycle, or,
//               with CPU_ISSUE_FWD_EN defined, are resolved by forwarding
//               alu_res into the operand registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_issue
    import cpu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int IMM_W  = IMM_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [2:0]        alu_op,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    input  logic [31:0]       alu_res,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    // Decoded fields
    logic [2:0]        op;
    logic              imm_sel;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [31:0]       imm_ext;
    logic              legal;

    assign op      = instr[OP_LSB +: 3];
    assign imm_sel = instr[IMM_SEL_BIT];
    assign rd      = instr[RD_LSB +: REG_AW];
    assign rs1     = instr[RS1_LSB +: REG_AW];
    assign rs2     = instr[RS2_LSB +: REG_AW];
    assign imm_ext = {{(32 - IMM_W){instr[IMM_LSB + IMM_W - 1]}}, instr[IMM_LSB +: IMM_W]};
    assign legal   = is_legal_op(op);

    logic [31:0] rf_a;
    logic [31:0] rf_b;

    cpu_regfile #(
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (rs2),
        .rd_data_b (rf_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wb_valid),
        .wr_addr   (wb_rd),
        .wr_data   (alu_res)
    );

    // EX instruction produces a value some operand of the incoming one needs
    logic ex_writes;
    logic match_a;
    logic match_b;

    assign ex_writes = wb_valid && (wb_rd != '0);
    assign match_a   = ex_writes && (rs1 == wb_rd);
    assign match_b   = ex_writes && !imm_sel && (rs2 == wb_rd);

    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hazard;

    // Operand selection and hazard detection
    always_comb begin
        src_a  = rf_a;
        src_b  = imm_sel ? imm_ext : rf_b;
        hazard = 1'b0;
`ifdef CPU_ISSUE_FWD_EN
        if (match_a) begin
            src_a = alu_res;
        end
        if (match_b) begin
            src_b = alu_res;
        end
`else
        // Illegal ops are consumed as bubbles, so they never need to wait
        hazard = legal && (match_a || match_b);
`endif
    end

    assign instr_ready = !hazard;

    logic accept;
    assign accept = instr_valid && instr_ready;

    // EX register: load on a legal accept, bubble otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op   <= OP_MOV;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_rd    <= '0;
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= accept && legal;
            illegal  <= accept && !legal;
            if (accept && legal) begin
                alu_op <= op;
                alu_a  <= src_a;
                alu_b  <= src_b;
                wb_rd  <= rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_issue
// Description : Self-checking bench for cpu_issue: reset checks, a directed
//               vector table, randomized instructions against an
//               architectural register model, and reset during writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        illegal;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks   = 0;
    int failures = 0;

`ifdef CPU_ISSUE_FWD_EN
    localparam int S = 0;
`else
    localparam int S = 1;
`endif

    cpu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_res     (alu_res),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'b000:  return b;
            3'b001:  return a + b;
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural ALU downstream of the stage
    always_comb alu_res = alu_f(alu_op, alu_a, alu_b);

    function automatic logic [31:0] mk(input logic [2:0] op, input logic isel,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2, input logic [15:0] imm);
        return {op, isel, rd, rs1, rs2, imm};
    endfunction

    function automatic logic op_ok(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
    endfunction

    // Architectural register state as seen by a sequential program
    logic [31:0] mreg [16];
    logic [3:0]  prev_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        prev_rd = 4'd0;
    endtask

    // Called at a negedge; returns at the negedge right after acceptance
    task automatic send(input logic [31:0] w, input int exp_stall);
        logic [2:0]  op;
        logic        isel;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        lg;
        int          stalls;
        op   = w[31:29];
        isel = w[28];
        rd   = w[27:24];
        rs1  = w[23:20];
        rs2  = w[19:16];
        lg   = op_ok(op);
        ea   = mreg[rs1];
        eb   = isel ? {{16{w[15]}}, w[15:0]} : mreg[rs2];
        stalls = 0;
        instr = w;
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && stalls < 4) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        chk("stall_cycles", stalls, exp_stall);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("wb_valid", wb_valid, lg);
        chk("illegal", illegal, !lg);
        if (lg) begin
            chk("alu_op", alu_op, op);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("wb_rd", wb_rd, rd);
            if (rd != 4'd0) mreg[rd] = alu_f(op, ea, eb);
            prev_rd = rd;
        end else begin
            prev_rd = 4'd0;
        end
    endtask

    typedef struct {
        logic [31:0] w;
        int          stall;
        bit          chk_en;
        logic [3:0]  rd;
        logic [31:0] val;
    } vec_t;

    vec_t vt [13];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        prev_rd = 4'd0;

        vt[0]  = '{mk(3'b001, 1'b1, 4'd1, 4'd0, 4'd0, 16'h0005), 0, 1'b0, 4'd0, 32'h0};
        vt[1]  = '{mk(3'b001, 1'b1, 4'd2, 4'd1, 4'd0, 16'h0003), S, 1'b1, 4'd2, 32'h8};
        vt[2]  = '{mk(3'b001, 1'b1, 4'd1, 4'd0, 4'd0, 16'h0F0F), 0, 1'b0, 4'd0, 32'h0};
        vt[3]  = '{mk(3'b001, 1'b1, 4'd2, 4'd0, 4'd0, 16'h00FF), 0, 1'b0, 4'd0, 32'h0};
        vt[4]  = '{mk(3'b100, 1'b0, 4'd3, 4'd1, 4'd2, 16'h0000), S, 1'b0, 4'd0, 32'h0};
        vt[5]  = '{mk(3'b110, 1'b0, 4'd4, 4'd1, 4'd2, 16'h0000), 0, 1'b0, 4'd0, 32'h0};
        vt[6]  = '{mk(3'b111, 1'b0, 4'd5, 4'd1, 4'd2, 16'h0000), 0, 1'b1, 4'd5, 32'h0000000F};
        vt[7]  = '{mk(3'b001, 1'b1, 4'd6, 4'd0, 4'd0, 16'hFFFF), 0, 1'b1, 4'd6, 32'hFFFFFFFF};
        vt[8]  = '{mk(3'b001, 1'b1, 4'd7, 4'd6, 4'd0, 16'h0001), 0, 1'b1, 4'd7, 32'h0};
        vt[9]  = '{mk(3'b000, 1'b0, 4'd0, 4'd0, 4'd1, 16'h0000), 0, 1'b0, 4'd0, 32'h0};
        vt[10] = '{mk(3'b001, 1'b1, 4'd8, 4'd0, 4'd0, 16'h0002), 0, 1'b1, 4'd8, 32'h2};
        vt[11] = '{mk(3'b010, 1'b1, 4'd1, 4'd1, 4'd0, 16'h0007), 0, 1'b0, 4'd0, 32'h0};
        vt[12] = '{mk(3'b001, 1'b1, 4'd9, 4'd1, 4'd0, 16'h0000), 0, 1'b1, 4'd9, 32'h00000F0F};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_alu_op", alu_op, 3'b000);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            chk("rst_rf", dbg_data, 32'h0);
        end
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            send(vt[i].w, vt[i].stall);
            if (vt[i].chk_en) begin
                dbg_addr = vt[i].rd;
                idle();
                chk("vec_result", dbg_data, vt[i].val);
            end
        end
        idle();
        dbg_addr = 4'd3; #1; chk("xor_r3", dbg_data, 32'h00000FF0);
        dbg_addr = 4'd4; #1; chk("or_r4",  dbg_data, 32'h00000FFF);
        dbg_addr = 4'd0; #1; chk("r0_zero", dbg_data, 32'h0);
        dbg_addr = 4'd1; #1; chk("r1_kept", dbg_data, 32'h00000F0F);
        @(negedge clk);

        // Randomized program against the architectural model
        for (int k = 0; k < 300; k++) begin
            logic [31:0] w;
            int          es;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) idle();
            es = 0;
            if (op_ok(w[31:29]) && prev_rd != 4'd0 &&
                (w[23:20] == prev_rd || (!w[28] && w[19:16] == prev_rd)))
                es = S;
            send(w, es);
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            chk("rand_rf", dbg_data, mreg[i]);
        end
        @(negedge clk);

        // Reset while an instruction is in EX
        send(mk(3'b001, 1'b1, 4'd10, 4'd0, 4'd0, 16'h0055), 0);
        dbg_addr = 4'd10;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_wb_valid", wb_valid, 1'b0);
        chk("rst_mid_r10", dbg_data, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_mid_no_write", dbg_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        prev_rd = 4'd0;
        @(negedge clk);
        chk("post_rst_r10", dbg_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
